// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD digits from a multiplexed 7-segment bus
// A (dig_en, seg_in) pair is captured once after it has been stable for STABLE_CYCLES edges.
module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_en,
   input  logic                  err_clr,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t                state_q;
   logic [7:0]            count_q;
   logic [DIGITS-1:0]     dig_q;
   logic [6:0]            seg_q;
   logic [4*DIGITS-1:0]   bcd_q;
   logic [DIGITS-1:0]     valid_q;
   logic [DIGITS-1:0]     mask_q;
   logic                  frame_q;
   logic                  err_q;

   logic                  one_hot;
   logic                  pair_same;
   logic [3:0]            seg_nib;

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1111110: return 4'd0;
         7'b0110000: return 4'd1;
         7'b1101101: return 4'd2;
         7'b1111001: return 4'd3;
         7'b0110011: return 4'd4;
         7'b1011011: return 4'd5;
         7'b1011111: return 4'd6;
         7'b1110000: return 4'd7;
         7'b1111111: return 4'd8;
         7'b1111011: return 4'd9;
         7'b0000000: return 4'hF;
         default:    return 4'hE;
      endcase
   endfunction

   assign one_hot   = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);
   assign pair_same = (dig_en == dig_q) && (seg_in == seg_q);
   assign seg_nib   = seg_decode(seg_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 8'd0;
         dig_q   <= '0;
         seg_q   <= 7'd0;
         bcd_q   <= {DIGITS{4'hF}};
         valid_q <= '0;
         mask_q  <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         if (err_clr) begin
            err_q <= 1'b0;
         end
         if (!one_hot) begin
            state_q <= IDLE;
            count_q <= 8'd0;
         end else if (state_q == IDLE || !pair_same) begin
            // The edge that first sees a new pair counts as its first stable edge.
            state_q <= SETTLE;
            count_q <= 8'd1;
            dig_q   <= dig_en;
            seg_q   <= seg_in;
         end else if (state_q == SETTLE) begin
            if (count_q == 8'(STABLE_CYCLES - 1)) begin
               state_q <= HOLD;
               for (int i = 0; i < DIGITS; i++) begin
                  if (dig_en[i]) begin
                     bcd_q[4*i +: 4] <= seg_nib;
                     valid_q[i]      <= (seg_nib < 4'd10);
                  end
               end
               if (seg_nib == 4'hE) begin
                  err_q <= 1'b1;
               end
               if ((mask_q | dig_en) == {DIGITS{1'b1}}) begin
                  frame_q <= 1'b1;
                  mask_q  <= '0;
               end else begin
                  mask_q  <= mask_q | dig_en;
               end
            end else begin
               count_q <= count_q + 8'd1;
            end
         end
      end
   end

   assign bcd_out     = bcd_q;
   assign digit_valid = valid_q;
   assign frame_done  = frame_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
// Reference model tracks run length of each sampled pair and a set of captured digits.
module tb_seg7_scan_decoder;
   localparam int DIGITS        = 4;
   localparam int STABLE_CYCLES = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [6:0]          seg_in;
   logic [DIGITS-1:0]   dig_en;
   logic                err_clr;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   digit_valid;
   logic                frame_done;
   logic                err;

   int checks   = 0;
   int failures = 0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   logic [3:0]        m_nib [DIGITS];
   logic [DIGITS-1:0] m_valid;
   logic [DIGITS-1:0] m_seen;
   logic              m_frame;
   logic              m_err;
   int                run_len;
   bit                have_pair;
   logic [DIGITS-1:0] last_dig;
   logic [6:0]        last_seg;

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en), .err_clr(err_clr),
      .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_decode(input logic [6:0] s);
      for (int v = 0; v < 10; v++) if (s == pat[v]) return 4'(v);
      if (s == 7'd0) return 4'hF;
      return 4'hE;
   endfunction

   function automatic logic [4*DIGITS-1:0] exp_bcd();
      logic [4*DIGITS-1:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_nib[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'hF;
      m_valid = '0; m_seen = '0; m_frame = 1'b0; m_err = 1'b0;
      run_len = 0; have_pair = 0;
   endtask

   task automatic model_edge();
      logic [3:0] nib;
      bit         hot;
      m_frame = 1'b0;
      hot = ($countones(dig_en) == 1);
      if (!hot) begin
         run_len = 0; have_pair = 0;
      end else if (have_pair && dig_en == last_dig && seg_in == last_seg) begin
         run_len++;
      end else begin
         run_len = 1; have_pair = 1; last_dig = dig_en; last_seg = seg_in;
      end
      if (err_clr) m_err = 1'b0;
      if (hot && run_len == STABLE_CYCLES) begin
         nib = ref_decode(seg_in);
         for (int i = 0; i < DIGITS; i++) begin
            if (dig_en[i]) begin
               m_nib[i]   = nib;
               m_valid[i] = (nib < 10);
               m_seen[i]  = 1'b1;
            end
         end
         if (nib == 4'hE) m_err = 1'b1;
         if (&m_seen) begin
            m_frame = 1'b1;
            m_seen  = '0;
         end
      end
   endtask

   task automatic drive_edge(input logic [DIGITS-1:0] d, input logic [6:0] s, input logic c);
      dig_en = d; seg_in = s; err_clr = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; dig_en = '0; seg_in = 7'd0; err_clr = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bcd_out !== 16'hFFFF || digit_valid !== 4'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: bcd=%h valid=%b frame=%b err=%b, want bcd=ffff valid=0000 frame=0 err=0",
                  bcd_out, digit_valid, frame_done, err);
      end
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic test_sequence();
      logic [6:0] segs [4] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
      int frames = 0;
      for (int d = 0; d < 4; d++) begin
         for (int e = 1; e <= 5; e++) begin
            drive_edge(4'(1 << d), segs[d], 1'b0);
            if (frame_done) frames++;
            checks++;
            if (bcd_out[4*d +: 4] !== ((e >= 3) ? 4'(d + 1) : 4'hF)) begin
               failures++;
               $display("FAIL seq_nibble d%0d e%0d: got %h want %h", d, e, bcd_out[4*d +: 4],
                        (e >= 3) ? 4'(d + 1) : 4'hF);
            end
            checks++;
            if (frame_done !== (d == 3 && e == 3)) begin
               failures++;
               $display("FAIL seq_frame d%0d e%0d: got %b want %b", d, e, frame_done, (d == 3 && e == 3));
            end
         end
      end
      checks++;
      if (bcd_out !== 16'h4321 || digit_valid !== 4'b1111 || frames != 1) begin
         failures++;
         $display("FAIL seq_final: bcd=%h valid=%b frames=%0d want 4321 1111 1", bcd_out, digit_valid, frames);
      end
   endtask

   task automatic test_glitch();
      int frames = 0;
      logic [15:0] held;
      for (int e = 0; e < 2; e++) begin
         drive_edge(4'b0001, 7'b1110000, 1'b0);
         checks++;
         if (bcd_out[3:0] === 4'd7) begin
            failures++;
            $display("FAIL glitch_short: got %h want not 7", bcd_out[3:0]);
         end
      end
      for (int e = 1; e <= 3; e++) begin
         drive_edge(4'b0001, 7'b1111001, 1'b0);
         checks++;
         if (bcd_out[3:0] !== ((e == 3) ? 4'd3 : 4'd1)) begin
            failures++;
            $display("FAIL glitch_cap e%0d: got %h want %h", e, bcd_out[3:0], (e == 3) ? 4'd3 : 4'd1);
         end
      end
      held = bcd_out;
      for (int e = 0; e < 20; e++) begin
         drive_edge(4'b0001, 7'b1111001, 1'b0);
         if (frame_done) frames++;
      end
      checks++;
      if (frames != 0 || bcd_out !== held) begin
         failures++;
         $display("FAIL glitch_hold: frames=%0d bcd=%h want 0 %h", frames, bcd_out, held);
      end
   endtask

   task automatic test_illegal();
      for (int e = 0; e < 3; e++) drive_edge(4'b0100, 7'b1000000, 1'b0);
      checks++;
      if (bcd_out[11:8] !== 4'hE || digit_valid[2] !== 1'b0 || err !== 1'b1) begin
         failures++;
         $display("FAIL illegal_cap: nib=%h valid=%b err=%b want e 0 1", bcd_out[11:8], digit_valid[2], err);
      end
      drive_edge(4'b0000, 7'b0000000, 1'b0);
      drive_edge(4'b0100, 7'b1000000, 1'b0);
      drive_edge(4'b0100, 7'b1000000, 1'b0);
      drive_edge(4'b0100, 7'b1000000, 1'b1);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL illegal_set_wins: got %b want 1", err);
      end
      drive_edge(4'b0000, 7'b0000000, 1'b1);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr: got %b want 0", err);
      end
   endtask

   task automatic test_blank_multihot();
      logic [15:0] b;
      logic [3:0]  v;
      for (int e = 0; e < 3; e++) drive_edge(4'b0001, 7'b0000000, 1'b0);
      checks++;
      if (bcd_out[3:0] !== 4'hF || digit_valid[0] !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL blank: nib=%h valid=%b err=%b want f 0 0", bcd_out[3:0], digit_valid[0], err);
      end
      b = bcd_out; v = digit_valid;
      for (int e = 0; e < 10; e++) drive_edge(4'b0011, 7'b1111111, 1'b0);
      checks++;
      if (bcd_out !== b || digit_valid !== v || err !== 1'b0) begin
         failures++;
         $display("FAIL multihot: bcd=%h valid=%b want %h %b", bcd_out, digit_valid, b, v);
      end
      for (int e = 0; e < 5; e++) drive_edge(4'b0000, 7'b1111111, 1'b0);
      checks++;
      if (bcd_out !== b || digit_valid !== v) begin
         failures++;
         $display("FAIL zero_en: bcd=%h valid=%b want %h %b", bcd_out, digit_valid, b, v);
      end
   endtask

   task automatic test_reset_mid();
      for (int e = 0; e < 3; e++) drive_edge(4'b0010, 7'b1111111, 1'b0);
      checks++;
      if (bcd_out[7:4] !== 4'd8) begin
         failures++;
         $display("FAIL mid_pre8: got %h want 8", bcd_out[7:4]);
      end
      drive_edge(4'b0100, 7'b0110000, 1'b0);
      drive_edge(4'b0100, 7'b0110000, 1'b0);
      test_reset();
      drive_edge(4'b0100, 7'b0110000, 1'b0);
      drive_edge(4'b0100, 7'b0110000, 1'b0);
      drive_edge(4'b0001, 7'b1011011, 1'b0);
      checks++;
      if (bcd_out !== 16'hFFFF || digit_valid !== 4'b0) begin
         failures++;
         $display("FAIL mid_short: bcd=%h valid=%b want ffff 0000", bcd_out, digit_valid);
      end
      drive_edge(4'b0001, 7'b1011011, 1'b0);
      drive_edge(4'b0001, 7'b1011011, 1'b0);
      checks++;
      if (bcd_out !== 16'hFFF5 || digit_valid !== 4'b0001) begin
         failures++;
         $display("FAIL mid_full: bcd=%h valid=%b want fff5 0001", bcd_out, digit_valid);
      end
   endtask

   task automatic test_random();
      logic [DIGITS-1:0] d;
      logic [6:0]        s;
      logic              c;
      int                r;
      for (int n = 0; n < 300; n++) begin
         d = 4'(1 << $urandom_range(0, DIGITS - 1));
         if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 11);
         s = (r < 10) ? pat[r] : ((r == 10) ? 7'd0 : 7'($urandom_range(0, 127)));
         for (int e = 0, len = $urandom_range(1, 5); e < len; e++) begin
            c = ($urandom_range(0, 7) == 0);
            drive_edge(d, s, c);
            checks++;
            if (bcd_out !== exp_bcd() || digit_valid !== m_valid || frame_done !== m_frame || err !== m_err) begin
               failures++;
               $display("FAIL random n%0d: bcd=%h valid=%b frame=%b err=%b want %h %b %b %b", n,
                        bcd_out, digit_valid, frame_done, err, exp_bcd(), m_valid, m_frame, m_err);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_glitch();
      test_illegal();
      test_blank_multihot();
      test_reset_mid();
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
